// File: rtl/data_mem_ctrl.sv
// Word-organised data memory behind a four-phase req/ack handshake with a fixed access latency.
// Optional bounds checking is enabled by defining DATA_MEM_BOUNDS_CHECK_EN.

module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_rd_wr,
  input  logic        mem_req_valid,
  output logic [31:0] mem_rd_data,
  output logic        mem_ack
);

  // state  | meaning
  // S_IDLE | waiting for mem_req_valid; captures the request bundle
  // S_WAIT | latency countdown; bus inputs ignored, access done when count hits 0
  // S_ACK  | mem_ack/mem_rd_data held until mem_req_valid is sampled low

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_wr;
  logic [AW-1:0] cap_idx;
  logic [31:0] cap_data;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] req_addr;
  logic [31:0] req_word;
  logic [31:0] access_data;
  logic        access_now;
  logic        mem_we;

  assign req_addr   = mem_rd_wr ? mem_wr_addr : mem_rd_addr;
  assign req_word   = req_addr >> 2;
  assign access_now = (state == S_WAIT) && (cnt == 4'd0);

`ifdef DATA_MEM_BOUNDS_CHECK_EN
  logic cap_oor;

  assign mem_we = access_now && cap_wr && !cap_oor;

  always_comb begin
    access_data = cap_wr ? cap_data : mem[cap_idx];
    if (cap_oor) access_data = 32'hDEAD_BEEF;
  end

  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE && mem_req_valid)
      cap_oor <= |(req_word >> AW);
  end
`else
  assign mem_we = access_now && cap_wr;

  always_comb begin
    access_data = cap_wr ? cap_data : mem[cap_idx];
  end
`endif

  // Array is deliberately left out of reset; a reset on the completion edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we)
      mem[cap_idx] <= cap_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      mem_ack     <= 1'b0;
      mem_rd_data <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_req_valid) begin
            cap_wr   <= mem_rd_wr;
            cap_idx  <= req_word[AW-1:0];
            cap_data <= mem_wr_data;
            cnt      <= LAT_M1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mem_rd_data <= access_data;
            mem_ack     <= 1'b1;
            state       <= S_ACK;
          end
        end
        S_ACK: begin
          if (!mem_req_valid) begin
            mem_ack <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed handshake scenarios plus a randomized
// phase, all checked against an array-based reference model of the memory.

module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] DECOY = 32'h40;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_rd_addr, mem_wr_addr, mem_wr_data;
  logic        mem_rd_wr, mem_req_valid;
  logic [31:0] mem_rd_data;
  logic        mem_ack;

  int tests = 0;
  int fails = 0;

  logic [31:0] ref_mem [DEPTH];
  bit          known   [DEPTH];
  logic [31:0] last_exp;
  bit          last_chk;

  data_mem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_wr(mem_rd_wr), .mem_req_valid(mem_req_valid),
    .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: byte address -> word, optional out-of-range trap, else modulo depth.
  function automatic logic [31:0] model_access(input bit wr, input logic [31:0] a,
                                               input logic [31:0] d, output bit chk);
    int unsigned w;
    w = a / 4;
`ifdef DATA_MEM_BOUNDS_CHECK_EN
    if (w >= DEPTH) begin
      chk = 1'b1;
      return 32'hDEAD_BEEF;
    end
`endif
    w = w % DEPTH;
    if (wr) begin
      ref_mem[w] = d;
      known[w]   = 1'b1;
      chk = 1'b1;
      return d;
    end
    chk = known[w];
    return ref_mem[w];
  endfunction

  // Bus noise during WAIT/ACK: a write to the decoy word that must never take effect.
  task automatic scramble();
    mem_rd_wr   = 1'b1;
    mem_wr_addr = DECOY;
    mem_rd_addr = DECOY;
    mem_wr_data = $urandom;
  endtask

  task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input int hold, input bit drop_early, input string tag);
    logic [31:0] exp;
    bit chk;
    @(negedge clk);
    mem_rd_wr     = wr;
    mem_rd_addr   = wr ? 32'($urandom) : addr;
    mem_wr_addr   = wr ? addr : 32'($urandom);
    mem_wr_data   = wr ? data : 32'($urandom);
    mem_req_valid = 1'b1;
    exp = model_access(wr, addr, data, chk);
    @(posedge clk); #1;
    check({tag, ":ack_accept"}, {31'b0, mem_ack}, 32'd0);
    if (drop_early) mem_req_valid = 1'b0;
    scramble();
    for (int k = 1; k <= int'(LAT); k++) begin
      @(posedge clk); #1;
      check({tag, ":ack_lat"}, {31'b0, mem_ack}, (k == int'(LAT)) ? 32'd1 : 32'd0);
      if (k < int'(LAT)) begin
        if (last_chk) check({tag, ":rd_hold_wait"}, mem_rd_data, last_exp);
        scramble();
      end
    end
    if (chk) check({tag, ":rd_data"}, mem_rd_data, exp);
    for (int h = 0; h < (drop_early ? 0 : hold); h++) begin
      scramble();
      @(posedge clk); #1;
      check({tag, ":ack_hold"}, {31'b0, mem_ack}, 32'd1);
      if (chk) check({tag, ":rd_stable"}, mem_rd_data, exp);
    end
    mem_req_valid = 1'b0;
    @(posedge clk); #1;
    check({tag, ":ack_clear"}, {31'b0, mem_ack}, 32'd0);
    if (chk) check({tag, ":rd_hold_idle"}, mem_rd_data, exp);
    last_exp = exp;
    last_chk = chk;
  endtask

  // Starts a write, then asserts reset k edges after acceptance (k = LAT is the completion edge).
  task automatic reset_abort(input logic [31:0] addr, input logic [31:0] data, input int k,
                             input string tag);
    @(negedge clk);
    mem_rd_wr = 1'b1; mem_wr_addr = addr; mem_wr_data = data; mem_req_valid = 1'b1;
    @(posedge clk); #1;
    repeat (k - 1) @(posedge clk);
    #1;
    reset = 1'b1;
    mem_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check({tag, ":ack_abort"}, {31'b0, mem_ack}, 32'd0);
    end
    check({tag, ":rd_reset"}, mem_rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    last_exp = 32'h0;
    last_chk = 1'b1;
  endtask

  initial begin
    logic [31:0] a, d;
    for (int i = 0; i < int'(DEPTH); i++) begin
      ref_mem[i] = 32'h0;
      known[i]   = 1'b0;
    end
    reset = 1'b1;
    mem_rd_addr = '0; mem_wr_addr = '0; mem_wr_data = '0;
    mem_rd_wr = 1'b0; mem_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'b0, mem_ack}, 32'd0);
    check("reset_rd", mem_rd_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    last_exp = 32'h0;
    last_chk = 1'b1;

    do_access(1'b1, DECOY, 32'h0BAD_0040, 0, 1'b0, "decoy_init");
    do_access(1'b1, 32'h10, 32'hA5A5_0001, 2, 1'b0, "t1_write");
    do_access(1'b0, 32'h10, 32'h0, 1, 1'b0, "t2_read10");
    do_access(1'b0, 32'h13, 32'h0, 0, 1'b0, "t2_read13");
    do_access(1'b1, 32'h50, 32'h3333_0050, 10, 1'b0, "t3_stuck");
    do_access(1'b0, DECOY, 32'h0, 0, 1'b0, "t3_decoy");
    do_access(1'b0, 32'h50, 32'h0, 0, 1'b0, "t3_read");

    do_access(1'b1, 32'h24, 32'h0000_AAAA, 0, 1'b0, "t4_pre24");
    @(negedge clk);
    mem_rd_wr = 1'b1; mem_wr_addr = 32'h20; mem_wr_data = 32'h1111; mem_req_valid = 1'b1;
    begin
      bit c;
      d = model_access(1'b1, 32'h20, 32'h1111, c);
    end
    @(posedge clk); #1;
    mem_wr_addr = 32'h24; mem_wr_data = 32'h2222;
    repeat (LAT) @(posedge clk);
    #1;
    check("t4_ack", {31'b0, mem_ack}, 32'd1);
    check("t4_echo", mem_rd_data, 32'h1111);
    mem_req_valid = 1'b0;
    @(posedge clk); #1;
    check("t4_clear", {31'b0, mem_ack}, 32'd0);
    last_exp = 32'h1111;
    do_access(1'b0, 32'h20, 32'h0, 0, 1'b0, "t4_read20");
    do_access(1'b0, 32'h24, 32'h0, 0, 1'b0, "t4_read24");

    do_access(1'b1, 32'h30, 32'h0000_0DD0, 0, 1'b0, "t5_pre");
    for (int k = 1; k <= int'(LAT); k++) begin
      reset_abort(32'h30, 32'hCAFE, k, "t5_abort");
      do_access(1'b0, 32'h30, 32'h0, 0, 1'b0, "t5_read");
    end

    do_access(1'b1, 32'h0, 32'h0000_1234, 0, 1'b0, "t6_pre0");
    do_access(1'b1, 32'h1000, 32'h77, 0, 1'b0, "t6_write");
    do_access(1'b0, 32'h1000, 32'h0, 0, 1'b0, "t6_read_hi");
    do_access(1'b0, 32'h0, 32'h0, 0, 1'b0, "t6_read0");

    do_access(1'b1, 32'h64, 32'h5A5A_0064, 0, 1'b1, "pulse_write");
    do_access(1'b0, 32'h64, 32'h0, 0, 1'b1, "pulse_read");

    for (int n = 0; n < 60; n++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) a = a | (32'($urandom) & 32'hFFFF_F000);
      d = $urandom;
      if ($urandom_range(0, 1) == 1)
        do_access(1'b1, a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd_write");
      else
        do_access(1'b0, a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rnd_read");
    end
    do_access(1'b0, DECOY, 32'h0, 0, 1'b0, "final_decoy");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
